fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Front stage of the fetch path; sits directly upstream of the instruction memory.
- Owns the program counter and drives it to the byte-addressed, big-endian instruction memory.
- Selects the next PC: sequential, branch, jump or jump-register. Captures the returned 32-bit instruction in an IF/ID register for the decoder.
- Handles stall, wrong-path flush, halt detection and misaligned-target trapping.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_BYTES, 128, instruction memory size in bytes; power of two, >= 8
HALT_OP, 6'b111111, opcode that halts fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  hazard hold; freezes PC and IF/ID
br_taken_i  in  1  branch of IF/ID instruction resolved taken
br_imm_i  in  16  branch immediate of IF/ID instruction
jump_i  in  1  j/jal in IF/ID
jaddr_i  in  26  jump target field
jr_i  in  1  jr in IF/ID
jr_target_i  in  32  register value for jr
inst_i  in  32  instruction word returned by instruction memory for pc_o
pc_o  out  32  current fetch address
ifid_inst_o  out  32  latched instruction
ifid_pc4_o  out  32  latched PC+4 of that instruction
ifid_valid_o  out  1  IF/ID holds a real instruction
halted_o  out  1  fetch stopped on HALT_OP
misalign_o  out  1  sticky; a redirect target had nonzero bits [1:0]

Behaviour:
- Reset (async, active-high), immediate effect, including mid-operation:
  - pc_o=RESET_PC; ifid_inst_o=0; ifid_pc4_o=0.
  - ifid_valid_o=0; halted_o=0; misalign_o=0; state=RUN.
- Memory interface is combinational: inst_i is valid in the same cycle as pc_o. Fetch-to-IF/ID latency is 1 cycle.
- pc4 = pc_o+4, computed mod 2^32.
- Next-PC selection, priority jr > jump > branch > sequential:
  - jr: jr_target_i
  - jump: {pc4_of_IFID[31:28], jaddr_i, 2'b00}, using ifid_pc4_o
  - branch: ifid_pc4_o + (sign_extend(br_imm_i) << 2)
  - sequential: pc4
- All redirect targets are computed relative to the IF/ID instruction. There is no delay slot.
- Wrap: every next PC is reduced mod MEM_BYTES, i.e. upper bits cleared. RESET_PC + 4 past MEM_BYTES-4 wraps to 0.
- Misalignment: a redirect target with bits [1:0] != 0 is forced to bits [1:0] = 0, and misalign_o is set. misalign_o clears only on rst.
- States: RUN, HALTED.
- RUN, stall_i=1:
  - pc_o and all IF/ID outputs hold.
  - Redirect inputs are ignored; their sources hold them because IF/ID is frozen.
- RUN, stall_i=0, any redirect:
  - pc_o <= selected target.
  - IF/ID flushed: ifid_valid_o=0, ifid_inst_o=0 (nop), ifid_pc4_o=0, because the word fetched this cycle is wrong-path.
- RUN, stall_i=0, no redirect:
  - pc_o <= pc4 (wrapped).
  - ifid_inst_o <= inst_i; ifid_pc4_o <= pc4; ifid_valid_o <= 1.
  - If inst_i[31:26]==HALT_OP: the instruction is still latched, pc_o holds (does not advance), and the next state is HALTED.
- HALTED:
  - halted_o=1; pc_o frozen.
  - Redirects ignored.
  - Next clock: ifid_valid_o <= 0, ifid_inst_o <= 0. IF/ID then stays at nop.
  - Exit only via rst.
- Simultaneous events:
  - stall beats redirect; redirect beats halt detection. A HALT word on the wrong path is flushed and does not halt.
  - Multiple redirects in one cycle resolve by priority; only the highest is taken.

Decomposition:
- Shared package holds:
  - opcode constants (HALT_OP, J, JAL, BEQ, BNE, SPECIAL, FUNCT_JR)
  - the fetch state enum {RUN, HALTED}
  - NOP word 32'h0
- One natural sub-module: next_pc_sel. It is combinational, takes pc4, ifid_pc4, the redirect controls and MEM_BYTES, and returns target, redirect and misalign.

Test Plan:
- Reset then 5 free-running clocks, inst_i=32'h2001_0005 -> pc_o 0,4,8,12,16. ifid_pc4_o = prior pc+4; ifid_valid_o=1 from cycle 1.
- IF/ID pc4=8, br_taken_i=1, br_imm_i=16'hFFFE -> pc_o=0 next cycle, ifid_valid_o=0. With br_imm_i=3 instead -> pc_o=20.
- jr_i=1 with jr_target_i=32'h26, jump_i=1 in the same cycle -> pc_o=32'h24 (jr wins), misalign_o=1 and stays 1.
- stall_i=1 for 3 cycles with br_taken_i=1 asserted -> pc_o and IF/ID unchanged. stall_i drops -> branch taken the following edge.
- pc_o=124, MEM_BYTES=128, no redirect -> pc_o=0 next cycle. inst_i=32'hFC00_0000 -> halted_o=1, pc_o frozen, ifid_valid_o=1 one cycle then 0. rst pulse asynchronously clears everything to the reset values.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: opcode constants, fetch state,
// NOP word and small address helpers.
package fetch_pc_unit_pkg;

   localparam logic [5:0]  OP_HALT    = 6'b111111;
   localparam logic [5:0]  OP_SPECIAL = 6'b000000;
   localparam logic [5:0]  OP_J       = 6'b000010;
   localparam logic [5:0]  OP_JAL     = 6'b000011;
   localparam logic [5:0]  OP_BEQ     = 6'b000100;
   localparam logic [5:0]  OP_BNE     = 6'b000101;
   localparam logic [5:0]  FUNCT_JR   = 6'b001000;

   localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Next-PC selection: prioritised redirect mux (jr > jump > branch > sequential),
// wrap into the instruction memory and misaligned-target detection.
module next_pc_sel
   import fetch_pc_unit_pkg::*;
#(
   parameter int MEM_BYTES = 128
) (
   input  logic [31:0] pc4,
   input  logic [31:0] ifid_pc4,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        jump,
   input  logic [25:0] jaddr,
   input  logic        br_taken,
   input  logic [15:0] br_imm,
   output logic [31:0] target,
   output logic        redirect,
   output logic        misalign
);

   localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

   logic [31:0] raw_s;
   logic [31:0] masked_s;

   // Pick the raw target by redirect priority.
   always_comb begin
      raw_s    = pc4;
      redirect = 1'b0;
      if (jr) begin
         raw_s    = jr_target;
         redirect = 1'b1;
      end else if (jump) begin
         raw_s    = {ifid_pc4[31:28], jaddr, 2'b00};
         redirect = 1'b1;
      end else if (br_taken) begin
         raw_s    = ifid_pc4 + br_offset(br_imm);
         redirect = 1'b1;
      end else begin
         raw_s    = pc4;
         redirect = 1'b0;
      end
   end

   // Wrap into memory; redirect targets are forced onto a word boundary.
   always_comb begin
      masked_s = raw_s & ADDR_MASK;
      misalign = 1'b0;
      target   = masked_s;
      if (redirect) begin
         misalign = (raw_s[1:0] != 2'b00);
         target   = word_align(masked_s);
      end else begin
         misalign = 1'b0;
         target   = masked_s;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front stage: owns the PC, drives instruction memory and captures the
// returned word into the IF/ID register; handles stall, flush, halt and trap.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 128,
   parameter logic [5:0]  HALT_OP   = OP_HALT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        br_taken_i,
   input  logic [15:0] br_imm_i,
   input  logic        jump_i,
   input  logic [25:0] jaddr_i,
   input  logic        jr_i,
   input  logic [31:0] jr_target_i,
   input  logic [31:0] inst_i,
   output logic [31:0] pc_o,
   output logic [31:0] ifid_inst_o,
   output logic [31:0] ifid_pc4_o,
   output logic        ifid_valid_o,
   output logic        halted_o,
   output logic        misalign_o
);

   fetch_state_e state_r, state_s;
   logic [31:0]  pc_r, pc_s;
   logic [31:0]  ifid_inst_r, ifid_inst_s;
   logic [31:0]  ifid_pc4_r, ifid_pc4_s;
   logic         ifid_valid_r, ifid_valid_s;
   logic         misalign_r, misalign_s;

   logic [31:0]  pc4_s;
   logic [31:0]  target_s;
   logic         redirect_s;
   logic         sel_misalign_s;

   assign pc4_s = pc_r + 32'd4;

   next_pc_sel #(
      .MEM_BYTES (MEM_BYTES)
   ) u_next_pc_sel (
      .pc4       (pc4_s),
      .ifid_pc4  (ifid_pc4_r),
      .jr        (jr_i),
      .jr_target (jr_target_i),
      .jump      (jump_i),
      .jaddr     (jaddr_i),
      .br_taken  (br_taken_i),
      .br_imm    (br_imm_i),
      .target    (target_s),
      .redirect  (redirect_s),
      .misalign  (sel_misalign_s)
   );

   // Next-state and next-register values; stall beats redirect beats halt.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      ifid_inst_s  = ifid_inst_r;
      ifid_pc4_s   = ifid_pc4_r;
      ifid_valid_s = ifid_valid_r;
      misalign_s   = misalign_r;
      case (state_r)
         RUN: begin
            if (stall_i) begin
               pc_s = pc_r;
            end else if (redirect_s) begin
               // The word fetched this cycle is wrong-path: flush it.
               pc_s         = target_s;
               ifid_inst_s  = NOP_WORD;
               ifid_pc4_s   = 32'h0000_0000;
               ifid_valid_s = 1'b0;
               misalign_s   = misalign_r | sel_misalign_s;
            end else begin
               ifid_inst_s  = inst_i;
               ifid_pc4_s   = pc4_s;
               ifid_valid_s = 1'b1;
               if (inst_i[31:26] == HALT_OP) begin
                  pc_s    = pc_r;
                  state_s = HALTED;
               end else begin
                  pc_s    = target_s;
                  state_s = RUN;
               end
            end
         end
         HALTED: begin
            ifid_inst_s  = NOP_WORD;
            ifid_valid_s = 1'b0;
         end
         default: begin
            state_s = RUN;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= RUN;
         pc_r         <= RESET_PC;
         ifid_inst_r  <= NOP_WORD;
         ifid_pc4_r   <= 32'h0000_0000;
         ifid_valid_r <= 1'b0;
         misalign_r   <= 1'b0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         ifid_inst_r  <= ifid_inst_s;
         ifid_pc4_r   <= ifid_pc4_s;
         ifid_valid_r <= ifid_valid_s;
         misalign_r   <= misalign_s;
      end
   end

   assign pc_o         = pc_r;
   assign ifid_inst_o  = ifid_inst_r;
   assign ifid_pc4_o   = ifid_pc4_r;
   assign ifid_valid_o = ifid_valid_r;
   assign halted_o     = (state_r == HALTED);
   assign misalign_o   = misalign_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed vectors push expected IF state,
// a monitor pops and compares one entry after each clock edge.
module tb_fetch_pc_unit;

   localparam logic [31:0] I_ADDI = 32'h2001_0005;
   localparam logic [31:0] I_HALT = 32'hFC00_0000;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        v;
      logic        h;
      logic        m;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        br_taken_i;
   logic [15:0] br_imm_i;
   logic        jump_i;
   logic [25:0] jaddr_i;
   logic        jr_i;
   logic [31:0] jr_target_i;
   logic [31:0] inst_i;
   logic [31:0] pc_o;
   logic [31:0] ifid_inst_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic        halted_o;
   logic        misalign_o;

   exp_t exp_q[$];
   int   n_tests;
   int   n_fail;
   logic [7:0] vec_id;

   fetch_pc_unit #(
      .RESET_PC  (32'h0000_0000),
      .MEM_BYTES (128),
      .HALT_OP   (6'b111111)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .br_taken_i   (br_taken_i),
      .br_imm_i     (br_imm_i),
      .jump_i       (jump_i),
      .jaddr_i      (jaddr_i),
      .jr_i         (jr_i),
      .jr_target_i  (jr_target_i),
      .inst_i       (inst_i),
      .pc_o         (pc_o),
      .ifid_inst_o  (ifid_inst_o),
      .ifid_pc4_o   (ifid_pc4_o),
      .ifid_valid_o (ifid_valid_o),
      .halted_o     (halted_o),
      .misalign_o   (misalign_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [7:0] id,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
      end
   endtask

   task automatic chk_all(input exp_t e);
      chk("pc_o",         e.id, pc_o,                 e.pc);
      chk("ifid_inst_o",  e.id, ifid_inst_o,          e.inst);
      chk("ifid_pc4_o",   e.id, ifid_pc4_o,           e.pc4);
      chk("ifid_valid_o", e.id, {31'd0, ifid_valid_o}, {31'd0, e.v});
      chk("halted_o",     e.id, {31'd0, halted_o},     {31'd0, e.h});
      chk("misalign_o",   e.id, {31'd0, misalign_o},   {31'd0, e.m});
   endtask

   // Monitor: the DUT presents new IF state after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_all(e);
         end
      end
   end

   task automatic idle_inputs();
      stall_i     = 1'b0;
      br_taken_i  = 1'b0;
      br_imm_i    = 16'h0000;
      jump_i      = 1'b0;
      jaddr_i     = 26'h0;
      jr_i        = 1'b0;
      jr_target_i = 32'h0000_0000;
      inst_i      = I_ADDI;
   endtask

   // Called at a negedge: drive one cycle of stimulus, queue expected result.
   task automatic step(input logic st, input logic br, input logic [15:0] imm,
                       input logic jp, input logic [25:0] ja,
                       input logic jr, input logic [31:0] jrt, input logic [31:0] inst,
                       input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic [31:0] e_pc4, input logic e_v, input logic e_h,
                       input logic e_m);
      exp_t e;
      stall_i     = st;
      br_taken_i  = br;
      br_imm_i    = imm;
      jump_i      = jp;
      jaddr_i     = ja;
      jr_i        = jr;
      jr_target_i = jrt;
      inst_i      = inst;
      e.id = vec_id; e.pc = e_pc; e.inst = e_inst; e.pc4 = e_pc4;
      e.v = e_v; e.h = e_h; e.m = e_m;
      exp_q.push_back(e);
      vec_id++;
      @(negedge clk);
   endtask

   task automatic seq(input logic [31:0] inst, input logic [31:0] e_pc,
                      input logic [31:0] e_inst, input logic [31:0] e_pc4,
                      input logic e_v, input logic e_h, input logic e_m);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0, inst,
           e_pc, e_inst, e_pc4, e_v, e_h, e_m);
   endtask

   task automatic reset_check(input logic [7:0] id);
      chk("rst pc_o",         id, pc_o,                  32'h0000_0000);
      chk("rst ifid_inst_o",  id, ifid_inst_o,           32'h0000_0000);
      chk("rst ifid_pc4_o",   id, ifid_pc4_o,            32'h0000_0000);
      chk("rst ifid_valid_o", id, {31'd0, ifid_valid_o}, 32'd0);
      chk("rst halted_o",     id, {31'd0, halted_o},     32'd0);
      chk("rst misalign_o",   id, {31'd0, misalign_o},   32'd0);
   endtask

   // Asynchronous reset pulse between edges, checked before any clock edge.
   task automatic async_reset(input logic [7:0] id);
      #2;
      rst = 1'b1;
      #1;
      reset_check(id);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      vec_id  = 8'd0;
      rst     = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset_check(8'd200);
      rst = 1'b0;

      // Free-running sequential fetch.
      seq(I_ADDI, 32'd4,  I_ADDI, 32'd4,  1'b1, 1'b0, 1'b0);
      seq(I_ADDI, 32'd8,  I_ADDI, 32'd8,  1'b1, 1'b0, 1'b0);
      seq(I_ADDI, 32'd12, I_ADDI, 32'd12, 1'b1, 1'b0, 1'b0);
      seq(I_ADDI, 32'd16, I_ADDI, 32'd16, 1'b1, 1'b0, 1'b0);
      seq(I_ADDI, 32'd20, I_ADDI, 32'd20, 1'b1, 1'b0, 1'b0);

      async_reset(8'd201);

      // Branches relative to IF/ID pc4 = 8.
      seq(I_ADDI, 32'd4, I_ADDI, 32'd4, 1'b1, 1'b0, 1'b0);
      seq(I_ADDI, 32'd8, I_ADDI, 32'd8, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0, I_ADDI,
           32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      seq(I_ADDI, 32'd4, I_ADDI, 32'd4, 1'b1, 1'b0, 1'b0);
      seq(I_ADDI, 32'd8, I_ADDI, 32'd8, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0, I_ADDI,
           32'd20, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

      // jr beats jump and branch; misaligned target trapped and sticky.
      step(1'b0, 1'b1, 16'h0005, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_0026, I_ADDI,
           32'h24, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      seq(I_ADDI, 32'h28, I_ADDI, 32'h28, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 16'h0007, 1'b1, 26'h000_0005, 1'b0, 32'h0, I_ADDI,
           32'h14, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Stall holds everything and masks a pending branch.
      seq(I_ADDI, 32'h18, I_ADDI, 32'h18, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 16'h0001, 1'b0, 26'h0, 1'b0, 32'h0, 32'h1234_5678,
              32'h18, I_ADDI, 32'h18, 1'b1, 1'b0, 1'b1);
      end
      step(1'b0, 1'b1, 16'h0001, 1'b0, 26'h0, 1'b0, 32'h0, I_ADDI,
           32'h1C, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Wrong-path HALT word is flushed, then wrap past the top of memory.
      step(1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b1, 32'h0000_0078, I_HALT,
           32'h78, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      seq(I_ADDI, 32'h7C, I_ADDI, 32'h7C, 1'b1, 1'b0, 1'b1);
      seq(I_ADDI, 32'h00, I_ADDI, 32'h80, 1'b1, 1'b0, 1'b1);

      // HALT: word latched, PC frozen, IF/ID drops to nop, redirects ignored.
      seq(I_HALT, 32'h00, I_HALT, 32'h04, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b1, 32'h0000_0040, I_ADDI,
           32'h00, 32'd0, 32'h04, 1'b0, 1'b1, 1'b1);
      seq(I_ADDI, 32'h00, 32'd0, 32'h04, 1'b0, 1'b1, 1'b1);

      async_reset(8'd202);
      seq(I_ADDI, 32'd4, I_ADDI, 32'd4, 1'b1, 1'b0, 1'b0);

      for (int k = 0; k < 5; k++) begin
         if (exp_q.size() != 0) @(negedge clk);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
